// File: rtl/perm_round_engine.sv
// Iterative handshaked bit-permutation engine: accepts a line, applies P for `rounds` clocks, holds result.
// Optional macro PERM_INVERSE_EN adds an `inverse` input selecting P^-1 per transaction.
module perm_round_engine #(
    parameter int unsigned LINE_SIZE = 64,
    parameter int unsigned STRIDE    = 5,
    parameter int unsigned OFFSET    = 0,
    parameter int unsigned ROUND_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LINE_SIZE-1:0] line,
    input  logic [ROUND_W-1:0]   rounds,
`ifdef PERM_INVERSE_EN
    input  logic                 inverse,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LINE_SIZE-1:0] permutationOutput,
    output logic                 busy
);

    function automatic int unsigned gcd(input int unsigned a_in, input int unsigned b_in);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // A non-coprime stride would map several outputs onto one source bit.
    if (gcd(STRIDE, LINE_SIZE) != 1) begin : g_stride_check
        $fatal(1, "perm_round_engine: STRIDE must be coprime with LINE_SIZE");
    end
    if (OFFSET >= LINE_SIZE) begin : g_offset_check
        $fatal(1, "perm_round_engine: OFFSET must be below LINE_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LINE_SIZE-1:0] line_q,  line_d;
    logic [ROUND_W-1:0]   cnt_q,   cnt_d;
    logic [LINE_SIZE-1:0] fwd;
    logic [LINE_SIZE-1:0] round_out;

    for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_perm
        localparam int unsigned SRC = (STRIDE * gi + OFFSET) % LINE_SIZE;
        assign fwd[gi] = line_q[SRC];
    end

`ifdef PERM_INVERSE_EN
    logic                 inv_q, inv_d;
    logic [LINE_SIZE-1:0] bwd;

    for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_perm_inv
        localparam int unsigned DST = (STRIDE * gi + OFFSET) % LINE_SIZE;
        assign bwd[DST] = line_q[gi];
    end

    assign round_out = inv_q ? bwd : fwd;
`else
    assign round_out = fwd;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PERM_INVERSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
`ifdef PERM_INVERSE_EN
        inv_d     = inv_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    line_d  = line;
                    cnt_d   = rounds;
`ifdef PERM_INVERSE_EN
                    inv_d   = inverse;
`endif
                    state_d = (rounds != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy   = 1'b1;
                line_d = round_out;
                cnt_d  = cnt_q - ROUND_W'(1);
                if (cnt_q == ROUND_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign permutationOutput = line_q;

endmodule

// File: doc/perm_round_engine.md
Name: perm_round_engine

Overview:
Iterative, handshaked successor to the single-shot line-register-plus-permutation datapath.
- Accepts a LINE_SIZE-bit line and a per-transaction round count.
- Applies a parametrised bit permutation once per clock for that many rounds.
- Holds the result until the consumer takes it.
- Sits between the line source and downstream hashing/mixing stages in the Permutation Function project.

Parameters:
LINE_SIZE, 64, width of line and result in bits.
STRIDE, 5, permutation multiplier; must be coprime with LINE_SIZE (elaboration-time check, fatal if not).
OFFSET, 0, permutation additive offset, 0..LINE_SIZE-1.
ROUND_W, 5, width of the round-count input.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  producer has a line
in_ready  out  1  engine can accept a line
line  in  LINE_SIZE  input line
rounds  in  ROUND_W  number of permutation rounds, 0..2^ROUND_W-1
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
permutationOutput  out  LINE_SIZE  result line
busy  out  1  high in RUN state

Behaviour:
- Reset: rst low forces the following, regardless of clk:
  - state IDLE, state register 0, round counter 0.
  - in_ready=1, out_valid=0, busy=0, permutationOutput=0.
- Reset mid-operation aborts the transaction; there is no partial output.
- Round function P: out[i] = in[(STRIDE*i + OFFSET) mod LINE_SIZE] for i=0..LINE_SIZE-1. It is purely combinational on the state register.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: state reg <= line, counter <= rounds.
  - Next state is RUN if rounds!=0, else DONE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: state reg <= P(state reg), counter <= counter-1.
  - When counter==1 at the edge, next state is DONE.
- DONE:
  - out_valid=1; permutationOutput = state reg, held stable while out_ready=0.
  - On out_ready=1 at an edge: next state IDLE.
  - There is no same-cycle re-accept: in_ready stays 0 in DONE.
- permutationOutput is driven from the state register in all states; it is only meaningful while out_valid=1.
- Latency, counted from the accept edge: out_valid rises after rounds+1 edges, minimum 1 edge (rounds=0, pass-through).
- Throughput: one transaction per rounds+2 cycles, assuming out_ready is held high.
- line and rounds are sampled only at the accept edge; later changes are ignored.
- in_valid while not ready has no effect; the producer must hold it.
- Counter width is ROUND_W; it never underflows because RUN is never entered with 0.
- Maximum rounds 2^ROUND_W-1 is supported without wrap.

Optional Feature:
Macro: PERM_INVERSE_EN.
- Defined:
  - Adds input port inverse (1 bit), sampled at the accept edge.
  - When inverse=1, each round applies P^-1: out[(STRIDE*i + OFFSET) mod LINE_SIZE] = in[i].
  - This ensures that k rounds of P followed by k rounds of P^-1 restore the original line.
- Not defined:
  - Port inverse is absent.
  - Only P is implemented, with no extra logic.

Test Plan:
1. Reset check: LINE_SIZE=8, STRIDE=3, OFFSET=0; assert rst=0 mid-RUN -> in the same cycle (asynchronous), in_ready=1, out_valid=0, busy=0, permutationOutput=8'h00.
2. Single round: line=8'h02, rounds=1 -> out_valid after 2 edges, permutationOutput=8'h08 (out[3]=in[9 mod 8=1]).
3. Two rounds: line=8'h02, rounds=2 -> permutationOutput=8'h02, since P^2 is the identity for STRIDE=3 and LINE_SIZE=8; out_valid after 3 edges.
4. Pass-through: line=8'hA5, rounds=0 -> out_valid after 1 edge, permutationOutput=8'hA5, busy never high.
5. Back-pressure: rounds=1, out_ready=0 for 5 cycles -> out_valid and permutationOutput=8'h08 stable all 5 cycles, in_ready=0. Then out_ready=1 -> IDLE next edge, in_ready=1. A new line presented in DONE is not accepted.
6. With PERM_INVERSE_EN, LINE_SIZE=8, STRIDE=3, OFFSET=1: line=8'h02, inverse=0, rounds=1 -> 8'h01 (out[0]=in[1]). Feed 8'h01 back with inverse=1, rounds=1 -> 8'h02.
